// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants and decode helper.
// Used by vga_timing_gen and vga_pix_strobe.
package vga_timing_pkg;

    localparam int VGA_CNT_W = 10;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam int DEF_CLK_DIV   = 4;

    localparam int H_TOTAL      = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL      = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int H_SYNC_START = DEF_H_VISIBLE + DEF_H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
    localparam int V_SYNC_START = DEF_V_VISIBLE + DEF_V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

    // Half-open interval test [lo, hi) on counter values.
    function automatic logic in_range(input logic [VGA_CNT_W-1:0] val,
                                      input logic [VGA_CNT_W-1:0] lo,
                                      input logic [VGA_CNT_W-1:0] hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/vga_pix_strobe.sv
// Modulo-CLK_DIV divider producing a registered one-clk pixel strobe.
// Only instantiated when VGA_CLKDIV_EN is defined.
module vga_pix_strobe
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_pix_en,
    output logic o_pix_en_next
);

    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_pix_en;
    logic             w_last;

    assign w_last = (r_div == DIV_LAST);

    // Strobe is loaded from the last divider phase, so it first rises CLK_DIV edges after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div    <= '0;
            r_pix_en <= 1'b0;
        end else begin
            r_div    <= w_last ? '0 : r_div + DIV_W'(1);
            r_pix_en <= w_last;
        end
    end

    assign o_pix_en      = r_pix_en;
    assign o_pix_en_next = w_last;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel counters, active-low syncs, visible flag, frame_end.
// Define VGA_CLKDIV_EN to derive pix_en from the system clock via vga_pix_strobe.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int CLK_DIV   = DEF_CLK_DIV
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 pix_en,
    output logic [VGA_CNT_W-1:0] h_cnt,
    output logic [VGA_CNT_W-1:0] v_cnt,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 valid,
    output logic                 frame_end
);

    localparam logic [VGA_CNT_W-1:0] H_VIS  = VGA_CNT_W'(H_VISIBLE);
    localparam logic [VGA_CNT_W-1:0] H_SS   = VGA_CNT_W'(H_VISIBLE + H_FP);
    localparam logic [VGA_CNT_W-1:0] H_SE   = VGA_CNT_W'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [VGA_CNT_W-1:0] H_LAST = VGA_CNT_W'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [VGA_CNT_W-1:0] V_VIS  = VGA_CNT_W'(V_VISIBLE);
    localparam logic [VGA_CNT_W-1:0] V_SS   = VGA_CNT_W'(V_VISIBLE + V_FP);
    localparam logic [VGA_CNT_W-1:0] V_SE   = VGA_CNT_W'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [VGA_CNT_W-1:0] V_LAST = VGA_CNT_W'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);

    logic                 w_pix_en;
    logic                 w_pix_en_next;
    logic [VGA_CNT_W-1:0] r_h_cnt;
    logic [VGA_CNT_W-1:0] r_v_cnt;
    logic                 r_hsync;
    logic                 r_vsync;
    logic                 r_valid;
    logic                 r_frame_end;
    logic                 w_h_wrap;
    logic                 w_v_wrap;
    logic [VGA_CNT_W-1:0] w_h_next;
    logic [VGA_CNT_W-1:0] w_v_next;
    logic [VGA_CNT_W-1:0] w_h_upd;
    logic [VGA_CNT_W-1:0] w_v_upd;

`ifdef VGA_CLKDIV_EN
    vga_pix_strobe #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_strobe (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_pix_en      (w_pix_en),
        .o_pix_en_next (w_pix_en_next)
    );
`else
    // External pixel clock: strobe every cycle once out of reset.
    logic r_pix_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pix_en <= 1'b0;
        else        r_pix_en <= 1'b1;
    end

    assign w_pix_en      = r_pix_en;
    assign w_pix_en_next = 1'b1;
`endif

    assign w_h_wrap = (r_h_cnt == H_LAST);
    assign w_v_wrap = (r_v_cnt == V_LAST);
    assign w_h_next = w_h_wrap ? '0 : r_h_cnt + VGA_CNT_W'(1);
    assign w_v_next = !w_h_wrap ? r_v_cnt : (w_v_wrap ? '0 : r_v_cnt + VGA_CNT_W'(1));

    // Counter values that will be visible after this edge, strobe or not.
    assign w_h_upd = w_pix_en ? w_h_next : r_h_cnt;
    assign w_v_upd = w_pix_en ? w_v_next : r_v_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_hsync     <= 1'b1;
            r_vsync     <= 1'b1;
            r_valid     <= 1'b0;
            r_frame_end <= 1'b0;
        end else begin
            if (w_pix_en) begin
                r_h_cnt <= w_h_next;
                r_v_cnt <= w_v_next;
                r_hsync <= !in_range(w_h_next, H_SS, H_SE);
                r_vsync <= !in_range(w_v_next, V_SS, V_SE);
                r_valid <= (w_h_next < H_VIS) && (w_v_next < V_VIS);
            end
            // Coincides with the strobe cycle that sits on the last pixel of the frame.
            r_frame_end <= w_pix_en_next && (w_h_upd == H_LAST) && (w_v_upd == V_LAST);
        end
    end

    assign pix_en    = w_pix_en;
    assign h_cnt     = r_h_cnt;
    assign v_cnt     = r_v_cnt;
    assign hsync     = r_hsync;
    assign vsync     = r_vsync;
    assign valid     = r_valid;
    assign frame_end = r_frame_end;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full-size instance for reset/line checks,
// reduced-timing instance (16x10 total) for frame-level checks.
module tb_vga_timing_gen;

`ifdef VGA_CLKDIV_EN
    localparam int DIV = 4;
`else
    localparam int DIV = 1;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;

    logic       a_pix_en, a_hsync, a_vsync, a_valid, a_frame_end;
    logic [9:0] a_h, a_v;
    logic       b_pix_en, b_hsync, b_vsync, b_valid, b_frame_end;
    logic [9:0] b_h, b_v;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int a_fe_cnt = 0;
    int b_fe_cnt = 0;
    int b_fe_h, b_fe_v, b_fe_pe;
    int b_fe_stamp_last = 0;
    int b_fe_stamp_prev = 0;

    vga_timing_gen #(
        .CLK_DIV (DIV)
    ) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_en    (a_pix_en),
        .h_cnt     (a_h),
        .v_cnt     (a_v),
        .hsync     (a_hsync),
        .vsync     (a_vsync),
        .valid     (a_valid),
        .frame_end (a_frame_end)
    );

    // Small raster: H 8+2+3+3 = 16 (hsync [10,13)), V 4+2+2+2 = 10 (vsync [6,8)).
    vga_timing_gen #(
        .H_VISIBLE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_VISIBLE (4), .V_FP (2), .V_SYNC (2), .V_BP (2),
        .CLK_DIV   (DIV)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_en    (b_pix_en),
        .h_cnt     (b_h),
        .v_cnt     (b_v),
        .hsync     (b_hsync),
        .vsync     (b_vsync),
        .valid     (b_valid),
        .frame_end (b_frame_end)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_frame_end) a_fe_cnt <= a_fe_cnt + 1;
        if (b_frame_end) begin
            b_fe_cnt        <= b_fe_cnt + 1;
            b_fe_h          <= int'(b_h);
            b_fe_v          <= int'(b_v);
            b_fe_pe         <= int'(b_pix_en);
            b_fe_stamp_prev <= b_fe_stamp_last;
            b_fe_stamp_last <= cyc;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Advance to 1ns after the next edge on which the counters update.
    task automatic pix_step();
        int n = 0;
        while (!a_pix_en && n < 4 * DIV) begin
            @(posedge clk); #1;
            n++;
        end
        if (!a_pix_en) chk("pix_en_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs_low, hs_first, hs_last, vfall, steps, prev_valid, base;
        int vs_low, vs_first, vs_last, vis_cnt;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_h",         a_h, 0);
        chk("rst_v",         a_v, 0);
        chk("rst_hsync",     a_hsync, 1);
        chk("rst_vsync",     a_vsync, 1);
        chk("rst_valid",     a_valid, 0);
        chk("rst_pix_en",    a_pix_en, 0);
        chk("rst_frame_end", a_frame_end, 0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= DIV; k++) begin
            @(posedge clk); #1;
            chk((k == DIV) ? "first_pix_en" : "pix_en_low", a_pix_en, int'(k == DIV));
        end
        chk("h_before_strobe",  a_h, 0);
        chk("valid_00_blanked", a_valid, 0);
        @(posedge clk); #1;
        chk("h_after_strobe", a_h, 1);
        chk("valid_at_1_0",   a_valid, 1);
        chk("hsync_at_1_0",   a_hsync, 1);

        // One full line on the full-size instance.
        hs_low = 0; hs_first = -1; hs_last = -1; vfall = -1; steps = 0;
        prev_valid = a_valid;
        do begin
            pix_step();
            steps++;
            if (!a_hsync) begin
                if (hs_first < 0) hs_first = a_h;
                hs_last = a_h;
                hs_low++;
            end
            if (prev_valid != 0 && !a_valid && vfall < 0) vfall = a_h;
            prev_valid = a_valid;
        end while (a_h != 0 && steps < 1000);
        chk("line_steps",     steps, 799);
        chk("hsync_low_len",  hs_low, 96);
        chk("hsync_first_h",  hs_first, 656);
        chk("hsync_last_h",   hs_last, 751);
        chk("valid_fall_h",   vfall, 640);
        chk("v_after_wrap",   a_v, 1);
        chk("valid_at_0_1",   a_valid, 1);
        chk("vsync_line1",    a_vsync, 1);
        chk("a_no_frame_end", a_fe_cnt, 0);

        // Frame boundary on the small instance.
        base = b_fe_cnt; steps = 0;
        while (b_fe_cnt == base && steps < 400) begin
            pix_step();
            steps++;
        end
        chk("b_fe_seen",   b_fe_cnt - base, 1);
        chk("b_fe_h",      b_fe_h, 15);
        chk("b_fe_v",      b_fe_v, 9);
        chk("b_fe_pix_en", b_fe_pe, 1);
        chk("b_wrap_h",    b_h, 0);
        chk("b_wrap_v",    b_v, 0);
        chk("b_wrap_valid", b_valid, 1);

        // One complete small frame.
        base = b_fe_cnt; vs_low = 0; vs_first = -1; vs_last = -1; vis_cnt = 0;
        for (int i = 0; i < 160; i++) begin
            if (b_valid) vis_cnt++;
            if (!b_vsync) begin
                if (vs_first < 0) vs_first = b_v;
                vs_last = b_v;
                vs_low++;
            end
            pix_step();
        end
        chk("b_frame_pulses", b_fe_cnt - base, 1);
        chk("b_frame_period", b_fe_stamp_last - b_fe_stamp_prev, 160 * DIV);
        chk("b_vsync_len",    vs_low, 32);
        chk("b_vsync_first",  vs_first, 6);
        chk("b_vsync_last",   vs_last, 7);
        chk("b_visible_px",   vis_cnt, 32);
        chk("b_back_h",       b_h, 0);
        chk("b_back_v",       b_v, 0);

        // Asynchronous reset between clock edges.
        steps = 0;
        while (a_h != 300 && steps < 1000) begin
            pix_step();
            steps++;
        end
        chk("reach_h300", a_h, 300);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_h",      a_h, 0);
        chk("arst_v",      a_v, 0);
        chk("arst_hsync",  a_hsync, 1);
        chk("arst_valid",  a_valid, 0);
        chk("arst_pix_en", a_pix_en, 0);
        chk("arst_b_h",    b_h, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pix_step();
        chk("resume_h",     a_h, 1);
        chk("resume_v",     a_v, 0);
        chk("resume_valid", a_valid, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
